// File: rtl/ctrl_fsm_mc.sv
// ctrl_fsm_mc: multi-cycle fetch/decode/execute control FSM with start and memory handshakes.
// Define CTRL_PERF_CNT_EN to add saturating instr_cnt_o / stall_cnt_o counters.
module ctrl_fsm_mc #(
  parameter int INSTR_W = 9,
  parameter int OP_W    = 4,
  parameter int MEM_TO  = 15,
  parameter int TO_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               cond_i,
  input  logic               mem_ack_i,
  output logic               pc_adv_o,
  output logic               set_en_o,
  output logic               ac_ena_o,
  output logic               write_reg_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               branch_en_o,
  output logic               jump_en_o,
  output logic [INSTR_W-1:0] target_o,
  output logic               program_done_o,
  output logic               err_o,
  output logic               busy_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]        instr_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_BRTGT    = 4'd3,
    S_ACC      = 4'd4,
    S_WREG     = 4'd5,
    S_MEM_WAIT = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } state_e;

  state_e             state_q;
  logic [OP_W-1:0]    op_q;
  logic               cond_q;
  logic [TO_W-1:0]    to_q;
  logic [INSTR_W-1:0] target_q;
  logic               pc_adv_q, set_en_q, ac_ena_q, write_reg_q;
  logic               mem_req_q, mem_we_q, branch_en_q, jump_en_q;
  logic               done_q, err_q, busy_q;

  logic [OP_W-1:0]    op_s;
  logic [31:0]        op_u_s;
  logic               set_s, halt_s, jmp_s;
  logic               is_load_s, is_store_s, is_move_s, is_alu_s, is_br_s;

  // Field decode of the word the ROM is presenting this cycle.
  always_comb begin
    op_s       = instr_i[INSTR_W-2 -: OP_W];
    op_u_s     = 32'(op_s);
    set_s      = instr_i[INSTR_W-1];
    halt_s     = (instr_i == {INSTR_W{1'b1}});
    is_load_s  = (op_u_s == 32'd0);
    is_store_s = (op_u_s == 32'd1);
    is_move_s  = (op_u_s == 32'd2);
    is_alu_s   = (op_u_s >= 32'd3) && (op_u_s <= 32'd9);
    is_br_s    = (op_u_s >= 32'd10) && (op_u_s <= 32'd15);
    jmp_s      = (32'(op_q) == 32'd15);
  end

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= {OP_W{1'b0}};
      cond_q      <= 1'b0;
      to_q        <= {TO_W{1'b0}};
      target_q    <= {INSTR_W{1'b0}};
      pc_adv_q    <= 1'b0;
      set_en_q    <= 1'b0;
      ac_ena_q    <= 1'b0;
      write_reg_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      branch_en_q <= 1'b0;
      jump_en_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pc_adv_q    <= 1'b0;
      set_en_q    <= 1'b0;
      ac_ena_q    <= 1'b0;
      write_reg_q <= 1'b0;
      branch_en_q <= 1'b0;
      jump_en_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q  <= S_FETCH;
            pc_adv_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (set_s) begin
            state_q  <= S_ACC;
            ac_ena_q <= 1'b1;
            set_en_q <= 1'b1;
          end else if (is_load_s || is_store_s) begin
            state_q   <= S_MEM_WAIT;
            mem_req_q <= 1'b1;
            mem_we_q  <= is_store_s;
          end else if (is_move_s) begin
            state_q  <= S_ACC;
            ac_ena_q <= 1'b1;
          end else if (is_alu_s) begin
            state_q     <= S_WREG;
            write_reg_q <= 1'b1;
          end else if (is_br_s) begin
            state_q  <= S_BRTGT;
            pc_adv_q <= 1'b1;
            cond_q   <= cond_i;
            op_q     <= op_s;
          end else begin
            state_q  <= S_FETCH;
            pc_adv_q <= 1'b1;
          end
        end
        S_BRTGT: begin
          target_q <= instr_i;
          // An all-ones target halts only when the branch would actually be taken.
          if (halt_s && (jmp_s || cond_q)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= S_FETCH;
            pc_adv_q    <= 1'b1;
            jump_en_q   <= !halt_s && jmp_s;
            branch_en_q <= !halt_s && !jmp_s && cond_q;
          end
        end
        S_ACC, S_WREG: begin
          state_q  <= S_FETCH;
          pc_adv_q <= 1'b1;
        end
        S_MEM_WAIT: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            to_q      <= {TO_W{1'b0}};
            if (mem_we_q) begin
              state_q  <= S_FETCH;
              pc_adv_q <= 1'b1;
            end else begin
              state_q  <= S_ACC;
              ac_ena_q <= 1'b1;
            end
          end else if (to_q == TO_W'(MEM_TO - 1)) begin
            state_q   <= S_ERR;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            to_q      <= {TO_W{1'b0}};
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            to_q <= to_q + TO_W'(1'b1);
          end
        end
        S_DONE: state_q <= S_DONE;
        S_ERR:  state_q <= S_ERR;
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
          to_q      <= {TO_W{1'b0}};
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign pc_adv_o       = pc_adv_q;
  assign set_en_o       = set_en_q;
  assign ac_ena_o       = ac_ena_q;
  assign write_reg_o    = write_reg_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign branch_en_o    = branch_en_q;
  assign jump_en_o      = jump_en_q;
  assign target_o       = target_q;
  assign program_done_o = done_q;
  assign err_o          = err_q;
  assign busy_o         = busy_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt_q, stall_cnt_q;

  // Saturating counters of decoded instructions and unacknowledged memory-wait cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if ((state_q == S_DECODE) && (instr_cnt_q != 32'hFFFF_FFFF)) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
      if ((state_q == S_MEM_WAIT) && !mem_ack_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign instr_cnt_o = instr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// tb_ctrl_fsm_mc: directed plus randomized instruction streams for ctrl_fsm_mc, checked cycle by
// cycle against a per-instruction-class timeline model.
`timescale 1ns/1ps
module tb_ctrl_fsm_mc;
  localparam int MEM_TO = 15;

  // Flag vector order: pc_adv set_en ac_ena write_reg mem_req mem_we branch_en jump_en done err busy
  localparam logic [10:0] PC   = 11'b100_0000_0000;
  localparam logic [10:0] SETB = 11'b010_0000_0000;
  localparam logic [10:0] ACC  = 11'b001_0000_0000;
  localparam logic [10:0] WR   = 11'b000_1000_0000;
  localparam logic [10:0] MREQ = 11'b000_0100_0000;
  localparam logic [10:0] MWE  = 11'b000_0010_0000;
  localparam logic [10:0] BR   = 11'b000_0001_0000;
  localparam logic [10:0] JMP  = 11'b000_0000_1000;
  localparam logic [10:0] DONE = 11'b000_0000_0100;
  localparam logic [10:0] ERR  = 11'b000_0000_0010;
  localparam logic [10:0] BSY  = 11'b000_0000_0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cond = 1'b0;
  logic       mem_ack = 1'b0;
  logic [8:0] instr = 9'h000;
  logic       pc_adv, set_en, ac_ena, write_reg, mem_req, mem_we;
  logic       branch_en, jump_en, program_done, err, busy;
  logic [8:0] target;
  logic [10:0] obs;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          status = 0;
  logic [8:0]  exp_target = 9'h000;
  logic [10:0] pend = 11'b0;

  ctrl_fsm_mc dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .instr_i        (instr),
    .cond_i         (cond),
    .mem_ack_i      (mem_ack),
    .pc_adv_o       (pc_adv),
    .set_en_o       (set_en),
    .ac_ena_o       (ac_ena),
    .write_reg_o    (write_reg),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .branch_en_o    (branch_en),
    .jump_en_o      (jump_en),
    .target_o       (target),
    .program_done_o (program_done),
    .err_o          (err),
    .busy_o         (busy)
`ifdef CTRL_PERF_CNT_EN
    ,
    .instr_cnt_o    (instr_cnt),
    .stall_cnt_o    (stall_cnt)
`endif
  );

  assign obs = {pc_adv, set_en, ac_ena, write_reg, mem_req, mem_we,
                branch_en, jump_en, program_done, err, busy};

  always #5 clk = ~clk;

  function automatic logic [8:0] r9();
    return 9'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  // Compare the current cycle, then drive inputs for the edge that ends it.
  task automatic cyc(input logic [10:0] exp, input string tag, input logic [8:0] ins,
                     input logic c, input logic ack, input logic st);
    vectors++;
    assert ({target, obs} === {exp_target, exp})
      else begin
        miscompares++;
        $error("FAIL %s: observed target=%h flags=%b, expected target=%h flags=%b",
               tag, target, obs, exp_target, exp);
      end
    instr = ins;
    cond = c;
    mem_ack = ack;
    start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_x(input logic [10:0] exp, input string tag);
    cyc(exp, tag, r9(), r1(), r1(), r1());
  endtask

  task automatic kick();
    cyc(11'b0, "idle_start", r9(), r1(), r1(), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(11'b0, "idle", r9(), r1(), r1(), 1'b0);
  endtask

  task automatic hold(input logic [10:0] exp, input string tag, input int n);
    for (int k = 0; k < n; k++) cyc(exp, tag, r9(), r1(), r1(), (k % 2 == 0) ? 1'b1 : r1());
  endtask

  // Reset lands mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    #3;
    rst_n = 1'b0;
    start = 1'b0;
    mem_ack = 1'b0;
    #1;
    exp_target = 9'h000;
    pend = 11'b0;
    status = 0;
    vectors++;
    assert ({target, obs} === {exp_target, 11'b0})
      else begin
        miscompares++;
        $error("FAIL %s: observed target=%h flags=%b, expected target=%h flags=%b",
               tag, target, obs, exp_target, 11'b0);
      end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Timeline of one instruction from its FETCH cycle; w >= MEM_TO means no ack ever arrives.
  task automatic do_instr(input logic [8:0] ins, input logic c, input int w, input logic [8:0] tw);
    int op;
    logic [10:0] base;
    op = int'(ins[7:4]);
    cyc_x(PC | BSY | pend, "fetch");
    pend = 11'b0;
    cyc(BSY, "decode", ins, c, r1(), r1());
    if (ins[8]) begin
      cyc_x(ACC | SETB | BSY, "set_acc");
    end else if (op <= 1) begin
      base = MREQ | BSY | ((op == 1) ? MWE : 11'b0);
      if (w >= MEM_TO) begin
        for (int k = 0; k < MEM_TO; k++) cyc(base, "mem_wait", r9(), r1(), 1'b0, r1());
        status = 2;
      end else begin
        for (int k = 0; k < w; k++) cyc(base, "mem_wait", r9(), r1(), 1'b0, r1());
        cyc(base, "mem_ack", r9(), r1(), 1'b1, r1());
        if (op == 0) cyc_x(ACC | BSY, "load_acc");
      end
    end else if (op == 2) begin
      cyc_x(ACC | BSY, "move_acc");
    end else if (op <= 9) begin
      cyc_x(WR | BSY, "alu_wreg");
    end else begin
      cyc(PC | BSY, "brtgt", tw, r1(), r1(), r1());
      exp_target = tw;
      if (tw == 9'h1FF) begin
        if (op == 15 || c) status = 1;
      end else if (op == 15) begin
        pend = JMP;
      end else if (c) begin
        pend = BR;
      end
    end
  endtask

  initial begin
    logic [8:0] ins;
    logic [8:0] tw;
    int w;

    @(posedge clk);
    #1;
    do_reset("por");
    idle(3);

    kick();
    do_instr(9'h030, r1(), 0, 9'h000);
    do_instr(9'h000, r1(), 3, 9'h000);
    do_instr(9'h0A0, 1'b1, 0, 9'h025);
    do_instr(9'h0A0, 1'b0, 0, 9'h025);
    do_instr(9'h010, r1(), MEM_TO - 1, 9'h000);
    do_instr(9'h010, r1(), MEM_TO, 9'h000);
    hold(ERR, "err_sticky", 4);
    do_reset("err_reset");

    kick();
    cyc_x(PC | BSY, "fetch");
    cyc(BSY, "decode", 9'h000, r1(), r1(), r1());
    cyc(MREQ | BSY, "mem_wait", r9(), r1(), 1'b0, r1());
    cyc(MREQ | BSY, "mem_wait", r9(), r1(), 1'b0, r1());
    do_reset("mid_mem_wait");
    idle(3);

    kick();
    do_instr(9'h0F0, r1(), 0, 9'h1FF);
    hold(DONE, "done_sticky", 5);
    do_reset("done_reset");

    kick();
    for (int n = 0; n < 200; n++) begin
      ins = r9();
      w = ($urandom_range(0, 19) == 0) ? MEM_TO : int'($urandom_range(0, MEM_TO - 1));
      tw = ($urandom_range(0, 5) == 0) ? 9'h1FF : r9();
      do_instr(ins, r1(), w, tw);
      if (status != 0) begin
        hold((status == 1) ? DONE : ERR, "rand_sticky", 3);
        do_reset("rand_reset");
        kick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ctrl_fsm_mc.md
Name: ctrl_fsm_mc

Overview:
Parametrised multi-cycle control FSM for the accumulator-style core. It is the successor to the fixed 9-bit control decoder and generalises instruction and opcode width. It adds a start handshake, a memory request/acknowledge handshake with timeout, and an explicit error state. It sits between instruction ROM, ALU flags, data memory and the fetch unit.

Parameters:
INSTR_W, 9, instruction width; MSB is the SET bit.
OP_W, 4, opcode field width, taken from instr[INSTR_W-2 -: OP_W]; requires OP_W <= INSTR_W-1.
MEM_TO, 15, maximum cycles in MEM_WAIT before error; must be >= 1.
TO_W, 4, timeout counter width; requires 2^TO_W > MEM_TO.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; leaves IDLE
instr  in  INSTR_W  current instruction word from ROM
cond  in  1  ALU branch-condition flag
mem_ack  in  1  data memory completion
pc_adv  out  1  fetch unit advances PC this cycle
set_en  out  1  SET-class instruction (instr MSB=1) being executed
ac_ena  out  1  accumulator load enable
write_reg  out  1  register-file write enable
mem_req  out  1  memory request, held until ack
mem_we  out  1  qualifies mem_req: 1=store, 0=load
branch_en  out  1  conditional branch taken, target valid
jump_en  out  1  unconditional jump, target valid
target  out  INSTR_W  branch/jump target
program_done  out  1  sticky halt indication
err  out  1  sticky memory-timeout error
busy  out  1  high in every state except IDLE, DONE, ERR

Behaviour:
- Reset is asynchronous, active-low, and legal in any state. On reset: state=IDLE, all outputs 0, target=0, timeout counter=0.
- Opcode map (op=instr[INSTR_W-2 -: OP_W], SET bit=instr[INSTR_W-1]):
  - 0 load, 1 store, 2 move
  - 3..9 ALU (add, sub, and, or, lsl, lsr, assign)
  - 10 beq, 11 blt, 12 bge, 13 bgt, 14 bnq, 15 b
  - When OP_W>4, codes above 15 are NOP.
- State transitions:
  - IDLE: wait for start=1, then FETCH.
  - FETCH: pc_adv=1; next state DECODE.
  - DECODE:
    - SET=1 -> ACC: set_en=1.
    - load -> MEM_WAIT with mem_req=1, mem_we=0.
    - store -> MEM_WAIT with mem_req=1, mem_we=1.
    - move -> ACC.
    - ALU -> WREG.
    - branch class -> BRTGT: pc_adv=1; cond is captured into cond_q, op into op_q.
    - NOP -> FETCH.
  - BRTGT: instr now holds the target word; target<=instr.
    - instr all-ones (halt target): when op_q==b or cond_q==1 -> DONE; otherwise FETCH.
    - Other targets: jump_en=1 when op_q==b, else branch_en=cond_q; next state FETCH.
    - jump_en/branch_en are one-cycle pulses, coincident with target valid.
  - ACC: ac_ena=1 for one cycle; next state FETCH.
  - WREG: write_reg=1 for one cycle; next state FETCH.
  - MEM_WAIT: mem_req and mem_we are held constant.
    - mem_ack=1 -> drop mem_req. A load goes to ACC; a store goes to FETCH.
    - Timeout counter increments every cycle without ack. When it reaches MEM_TO with no ack -> ERR.
    - An ack on the same cycle as the counter reaching MEM_TO wins (no error).
    - The counter clears on leaving MEM_WAIT.
  - DONE: program_done=1, sticky; start is ignored; exit only via reset.
  - ERR: err=1, sticky; mem_req=0; exit only via reset.
- mem_ack outside MEM_WAIT is ignored.
- A start pulse outside IDLE is ignored.
- Latency per instruction class:
  - ALU/move/SET: 3 cycles
  - load: 4+wait cycles
  - store: 3+wait cycles
  - branch: 3 cycles
- All outputs are registered-state decodes; there is no combinational path from inputs to outputs.
- An illegal state encoding returns to IDLE.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: adds outputs instr_cnt[31:0] and stall_cnt[31:0].
  - instr_cnt increments on each DECODE.
  - stall_cnt increments on each MEM_WAIT cycle without ack.
  - Both reset to 0 and saturate at 2^32-1.
- Undefined: the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset, then start pulse, instr=9'h030 (add) -> pc_adv in cycle 1, write_reg=1 in cycle 3, then FETCH; no other enables asserted.
- instr=9'h000 (load), mem_ack asserted 3 cycles after mem_req -> mem_req high exactly 4 cycles with mem_we=0, then ac_ena=1 for one cycle.
- instr=9'h0A0 (beq), cond=1, next word 9'h025 -> target=9'h025, branch_en pulses once, jump_en=0. Repeat with cond=0 -> no branch_en.
- instr=9'h0F0 (b), next word 9'h1FF -> program_done=1 and stays high; a later start pulse has no effect.
- instr=9'h010 (store), mem_ack never arrives, MEM_TO=15 -> err=1 after 15 MEM_WAIT cycles, mem_req=0. Repeat with ack on cycle 15 -> no err.
- RST pulsed low mid-MEM_WAIT -> all outputs 0 immediately (asynchronous), state=IDLE; operation resumes only after start.
